// File: rtl/data_mem.sv
// Byte-addressable data memory: little-endian 16-bit word reads, byte or word stores,
// asynchronous active-low clear of the whole array.
module data_mem #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        str_byte,
    output logic [15:0] d_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];
    logic [ADDR_BITS-1:0] byte_addr;
    logic [ADDR_BITS-1:0] lo_addr;
    logic [ADDR_BITS-1:0] hi_addr;
    logic                 unused_addr_hi;

    assign byte_addr = Address[ADDR_BITS-1:0];
    // Word accesses force bit 0 low, so the high byte never wraps past the top.
    assign lo_addr   = {byte_addr[ADDR_BITS-1:1], 1'b0};
    assign hi_addr   = {byte_addr[ADDR_BITS-1:1], 1'b1};

    assign unused_addr_hi = ^Address[15:ADDR_BITS];

    always_comb begin
        mem_d = mem_q;
        if (MemWrite) begin
            if (str_byte) begin
                mem_d[byte_addr] = WriteData[7:0];
            end else begin
                mem_d[lo_addr] = WriteData[7:0];
                mem_d[hi_addr] = WriteData[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        d_out = '0;
        if (rst && MemRead) begin
            d_out = {mem_q[hi_addr], mem_q[lo_addr]};
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: reset behaviour, word/byte stores, aliasing,
// write gating and read-during-write visibility.
module tb_data_mem;

    logic        clk;
    logic        rst;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic        str_byte;
    logic [15:0] d_out;

    int unsigned n_cmp;
    int unsigned n_err;

    data_mem #(.ADDR_BITS(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .str_byte  (str_byte),
        .d_out     (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        #1;
        n_cmp++;
        assert (d_out === exp) else begin
            n_err++;
            $error("FAIL %s: d_out=%h expected=%h", tag, d_out, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        Address   = 16'h0004;
        WriteData = 16'h0000;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        str_byte  = 1'b0;

        check("reset_dout_gated", 16'h0000);
        tick();
        rst = 1'b1;
        check("reset_read", 16'h0000);

        // Word store and aligned reads
        MemWrite = 1'b1; str_byte = 1'b0; WriteData = 16'hABCD; Address = 16'h0004;
        tick();
        MemWrite = 1'b0;
        check("word_read_even", 16'hABCD);
        Address = 16'h0005;
        check("word_read_odd", 16'hABCD);
        Address = 16'h0006;
        check("word_neighbour", 16'h0000);

        // Asynchronous reset clears without a clock and beats a write edge
        Address = 16'h0004;
        #1;
        rst = 1'b0;
        check("reset_async_clear", 16'h0000);
        MemWrite = 1'b1; WriteData = 16'h1111;
        tick();
        MemWrite = 1'b0;
        rst = 1'b1;
        check("reset_after_release", 16'h0000);

        // Byte stores
        MemWrite = 1'b1; str_byte = 1'b1; WriteData = 16'hABCD; Address = 16'h0004;
        tick();
        Address = 16'h0005;
        MemWrite = 1'b0;
        Address = 16'h0004;
        check("byte_store_even", 16'h00CD);
        MemWrite = 1'b1; Address = 16'h0005;
        tick();
        MemWrite = 1'b0;
        Address = 16'h0004;
        check("byte_store_odd", 16'hCDCD);

        // Write gating with clocks running and data changing
        str_byte = 1'b0;
        for (int i = 0; i < 4; i++) begin
            WriteData = 16'h1000 + 16'(i);
            Address   = 16'h0004;
            tick();
        end
        check("no_write_when_disabled", 16'hCDCD);
        MemRead = 1'b0;
        check("read_disabled", 16'h0000);
        MemRead = 1'b1;
        Address = 16'h0044;
        check("alias_read", 16'hCDCD);

        // Aliased word store lands at 0x06
        MemWrite = 1'b1; WriteData = 16'h1234; Address = 16'h0046;
        tick();
        MemWrite = 1'b0;
        Address = 16'h0006;
        check("alias_write", 16'h1234);

        // Read during write: old value before edge, new value after
        MemWrite = 1'b1; WriteData = 16'h5678;
        check("rdw_before_edge", 16'h1234);
        tick();
        MemWrite = 1'b0;
        check("rdw_after_edge", 16'h5678);

        // Odd-address byte store only touches the high byte
        MemWrite = 1'b1; str_byte = 1'b1; WriteData = 16'hFF99; Address = 16'h0007;
        tick();
        MemWrite = 1'b0; str_byte = 1'b0;
        Address = 16'h0006;
        check("byte_store_high_only", 16'h9978);

        // Odd-address word store is aligned down
        MemWrite = 1'b1; WriteData = 16'hBEEF; Address = 16'h0009;
        tick();
        MemWrite = 1'b0;
        Address = 16'h0008;
        check("word_store_aligned", 16'hBEEF);
        Address = 16'h000A;
        check("word_store_no_spill", 16'h0000);

        // Top of memory: no wrap into address 0
        MemWrite = 1'b1; WriteData = 16'h1357; Address = 16'h003F;
        tick();
        MemWrite = 1'b0;
        check("top_word", 16'h1357);
        Address = 16'h0000;
        check("top_no_wrap", 16'h0000);

        // Mid-operation reset discards everything
        rst = 1'b0;
        #1;
        rst = 1'b1;
        Address = 16'h0004;
        check("reset_mid_op_04", 16'h0000);
        Address = 16'h003E;
        check("reset_mid_op_3e", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter: ADDR_BITS, default 6, byte-address width actually decoded; memory depth = 2**ADDR_BITS bytes (64 by default).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk, input, 1, rising-edge clock for all writes.
REQ-004 Port: rst, input, 1, asynchronous active-low reset.
REQ-005 Port: Address, input, 16, byte address; only Address[ADDR_BITS-1:0] decoded, upper bits ignored.
REQ-006 Port: WriteData, input, 16, store data.
REQ-007 Port: MemRead, input, 1, read enable.
REQ-008 Port: MemWrite, input, 1, write enable.
REQ-009 Port: str_byte, input, 1, when 1 a store writes one byte; when 0 a store writes a 16-bit word.
REQ-010 Port: d_out, output, 16, read data.

Function
REQ-011 Storage SHALL be a byte-addressable array of 2**ADDR_BITS 8-bit locations.
REQ-012 Word layout SHALL be little-endian: word at address A = {mem[A+1], mem[A]}.
REQ-013 Word accesses SHALL use the address with bit 0 forced to 0, so A is always even and A+1 never wraps past the top of memory.
REQ-014 Read SHALL be combinational: with MemRead=1, d_out = word at the aligned address, reflecting current array contents with zero latency.
REQ-015 With MemRead=0, d_out SHALL be 16'h0000.
REQ-016 Word store: on a rising clk with MemWrite=1, str_byte=0 and rst=1, the array SHALL take mem[A] <= WriteData[7:0] and mem[A+1] <= WriteData[15:8], with A aligned.
REQ-017 Byte store: on a rising clk with MemWrite=1, str_byte=1 and rst=1, the array SHALL take mem[Address[ADDR_BITS-1:0]] <= WriteData[7:0]. Byte stores are not aligned; odd addresses are legal. All other bytes are unchanged.
REQ-018 With MemWrite=0, the array SHALL not change; str_byte is then a don't-care.
REQ-019 Simultaneous MemRead and MemWrite: d_out SHALL show the old data before the edge and the new data combinationally after the edge.
REQ-020 Address and data outside a write edge SHALL have no effect on the array.
REQ-021 There is no handshake or busy signal; every write completes in one cycle.

Reset
REQ-022 While rst=0, every memory byte SHALL be cleared to 8'h00 asynchronously, with no clock required.
REQ-023 While rst=0, d_out SHALL be 16'h0000 regardless of MemRead.
REQ-024 While rst=0, writes SHALL be ignored; reset wins over a simultaneous MemWrite edge.
REQ-025 Reset asserted mid-operation SHALL discard all prior contents; after rst returns to 1, reads return 16'h0000 until written.

Verification
REQ-026 Reset read: rst=0, then rst=1, MemRead=1, Address=16'h0004 -> d_out=16'h0000.
REQ-027 Word store/read: MemWrite=1, str_byte=0, WriteData=16'hABCD, Address=16'h0004, one clk edge, then MemRead=1 -> d_out=16'hABCD; Address=16'h0005 reads the same 16'hABCD.
REQ-028 Reset clears: after the word store above, pulse rst=0 -> d_out=16'h0000 immediately while rst=0, and also after release with MemRead=1, Address=16'h0004.
REQ-029 Byte stores:
- MemWrite=1, str_byte=1, WriteData=16'hABCD, Address=16'h0004, one edge, then word read at 16'h0004 -> d_out=16'h00CD.
- Same store at Address=16'h0005 (following the first) -> d_out=16'hCDCD.
REQ-030 Write gating:
- MemWrite=0 with clocks running and WriteData changing -> contents unchanged.
- MemRead=0 -> d_out=16'h0000.
- Address=16'h0044 aliases to 16'h0004 with ADDR_BITS=6.
